// File: rtl/lfsr_gen_pkg.sv
// Shared types and default 16-bit constants for the LFSR generator family.
package lfsr_pkg;

  typedef enum logic {
    LFSR_GALOIS    = 1'b0,
    LFSR_FIBONACCI = 1'b1
  } lfsr_mode_e;

  localparam logic [15:0] LFSR16_TAPS_GALOIS = 16'hB400;
  localparam logic [15:0] LFSR16_TAPS_FIB    = 16'h002D;
  localparam logic [15:0] LFSR16_SEED        = 16'hACE1;

endpackage

// File: rtl/lfsr_gen_if.sv
// Control/status bundle between an LFSR generator and its consumer.
interface lfsr_gen_if #(
  parameter int unsigned WIDTH = 16
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             bit_out;
  logic             lockup;
  logic             seed_match;
  logic [WIDTH-1:0] period_len;

  modport master (
    output en, load, load_val,
    input  q, bit_out, lockup, seed_match, period_len
  );

  modport slave (
    input  en, load, load_val,
    output q, bit_out, lockup, seed_match, period_len
  );

endinterface

// File: rtl/lfsr_gen_step.sv
// One combinational LFSR step, Galois or Fibonacci right-shift.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = LFSR16_TAPS_GALOIS,
  parameter lfsr_mode_e       MODE  = LFSR_GALOIS
) (
  input  logic [WIDTH-1:0] s_in,
  output logic [WIDTH-1:0] s_out
);

  always_comb begin
    s_out = s_in;
    if (MODE == LFSR_GALOIS) begin
      s_out = s_in >> 1;
      if (s_in[0]) begin
        s_out = s_out ^ TAPS;
      end
    end else begin
      s_out = {^(s_in & TAPS), s_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator with reload, lock-up recovery and seed-return pulse.
// Define LFSR_PERIOD_CNT_EN to build the step counter that drives period_len.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH         = 16,
  parameter logic [WIDTH-1:0] TAPS          = LFSR16_TAPS_GALOIS,
  parameter logic [WIDTH-1:0] SEED          = LFSR16_SEED,
  parameter lfsr_mode_e       MODE          = LFSR_GALOIS,
  parameter int unsigned      STEPS_PER_CLK = 1
) (
  input logic       clk,
  input logic       reset,
  lfsr_gen_if.slave bus
);

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end
  if (WIDTH < 3 || WIDTH > 64) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be in 3..64");
  end
  if (STEPS_PER_CLK < 1 || STEPS_PER_CLK > WIDTH) begin : g_bad_steps
    $error("lfsr_gen: STEPS_PER_CLK must be in 1..WIDTH");
  end

  logic [WIDTH-1:0] q_r, q_nxt;
  logic             lock_r, lock_nxt;
  logic             match_r, match_nxt;
  logic [WIDTH-1:0] chain [STEPS_PER_CLK+1];

  assign chain[0] = q_r;

  for (genvar i = 0; i < STEPS_PER_CLK; i++) begin : g_step
    lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .MODE  (MODE)
    ) u_step (
      .s_in  (chain[i]),
      .s_out (chain[i+1])
    );
  end

  // load beats lock-up recovery, which beats a normal step
  always_comb begin
    q_nxt     = q_r;
    lock_nxt  = 1'b0;
    match_nxt = 1'b0;
    if (bus.load) begin
      q_nxt = bus.load_val;
    end else if (bus.en && q_r == '0) begin
      q_nxt    = SEED;
      lock_nxt = 1'b1;
    end else if (bus.en) begin
      q_nxt     = chain[STEPS_PER_CLK];
      match_nxt = (chain[STEPS_PER_CLK] == SEED);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r     <= SEED;
      lock_r  <= 1'b0;
      match_r <= 1'b0;
    end else begin
      q_r     <= q_nxt;
      lock_r  <= lock_nxt;
      match_r <= match_nxt;
    end
  end

  assign bus.q          = q_r;
  assign bus.bit_out    = q_r[0];
  assign bus.lockup     = lock_r;
  assign bus.seed_match = match_r;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] cnt_r, cnt_inc, period_r;

  assign cnt_inc = cnt_r + WIDTH'(STEPS_PER_CLK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= '0;
      period_r <= '0;
    end else if (bus.load || (bus.en && q_r == '0)) begin
      cnt_r <= '0;
    end else if (bus.en) begin
      if (match_nxt) begin
        period_r <= cnt_inc;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_inc;
      end
    end
  end

  assign bus.period_len = period_r;
`else
  assign bus.period_len = '0;
`endif

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised LFSR pseudo-random generator; successor to the fixed 16-bit Galois LFSR.
- Generalised in width, tap mask and seed, with Galois/Fibonacci mode and multiple steps per clock.
- Adds enable, synchronous reload, all-zero lock-up recovery and a seed-return (period) pulse.
- Feeds test-pattern, scrambler and noise sources in the design.

Parameters:
- WIDTH, 16: state width in bits, 3..64.
- TAPS, 16'hB400: tap/toggle mask, WIDTH bits; bit i set means bit i participates.
- SEED, 16'hACE1: reset and lock-up recovery value; must be non-zero (elaboration $error if zero).
- MODE, 0: 0 = Galois right-shift, 1 = Fibonacci right-shift.
- STEPS_PER_CLK, 1: LFSR steps per enabled clock, 1..WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  advance state by STEPS_PER_CLK steps this clock.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  current state (registered).
- bit_out  out  1  q[0], the bit shifted out by the next step.
- lockup  out  1  one-cycle pulse, all-zero state recovered.
- seed_match  out  1  one-cycle pulse, a step returned q to SEED.
- period_len  out  WIDTH  last measured period (optional feature).

Behaviour:
- Reset (async, active-high): q=SEED; lockup=0; seed_match=0; period_len=0; step counter=0.
- Galois single step: lsb=s[0]; s'=s>>1; if lsb then s'=s'^TAPS.
- Fibonacci single step: fb=^(s & TAPS); s'={fb, s[WIDTH-1:1]}.
- Per enabled clock: apply the single step STEPS_PER_CLK times, chained combinationally. Result registered; latency 1 clock.
- Priority per clock: load > lock-up recovery > en > hold.
- load=1: q<=load_val regardless of en; no step; step counter cleared; seed_match=0. A zero load_val is accepted.
- Lock-up: if q==0 and en=1 (load=0), then q<=SEED and lockup pulses 1 the following cycle. No step is taken. The zero state never propagates beyond one cycle of en.
- en=0 and load=0: q holds; pulses deassert.
- seed_match=1 for one cycle after an en-step whose result equals SEED. Not asserted on reset, load or lock-up recovery.
- Pulses are registered, aligned with the q update that caused them.
- Deasserting reset mid-operation restarts from SEED. No partial-step state survives.

Optional Feature:
- Macro LFSR_PERIOD_CNT_EN.
- Defined: a WIDTH-bit step counter increments by STEPS_PER_CLK per en-step, wrapping modulo 2^WIDTH. It clears on reset, load and lock-up recovery.
  - When seed_match fires, period_len<=counter value including this step, and the counter restarts at 0.
  - period_len is held otherwise.
- Undefined: no counter is built; period_len is tied to 0. The port list is unchanged.

Decomposition:
- Package lfsr_pkg:
  - lfsr_mode_e enum {LFSR_GALOIS, LFSR_FIBONACCI}.
  - Default constants LFSR16_TAPS_GALOIS=16'hB400, LFSR16_TAPS_FIB=16'h002D, LFSR16_SEED=16'hACE1.
- Sub-module lfsr_step: purely combinational single step, parametrised by WIDTH, TAPS and MODE. It is instantiated STEPS_PER_CLK times in a generate chain.

Test Plan:
- Galois defaults: reset, then en=1 → q=16'hACE1, E270, 7138, 389C on successive clocks; bit_out=1,0,0,0.
- MODE=1, TAPS=16'h002D, SEED=16'hACE1: en=1 → q=16'h5670 then 16'hAB38.
- STEPS_PER_CLK=2, Galois defaults: one enabled clock → q=16'h7138; next → 16'h1C4E.
- load=1 with load_val=0 and en=1 → q=0. Next clock en=1 → q=16'hACE1, lockup=1 for exactly one cycle. Also check: load=1 with en=1 and load_val=16'h1234 → q=16'h1234, no step.
- Galois defaults, en held for 65535 clocks → seed_match pulses exactly on clock 65535. With LFSR_PERIOD_CNT_EN, period_len=16'hFFFF.
- Assert reset mid-run (q≠SEED) → q=16'hACE1 immediately, all pulses 0. en=0 for 10 clocks → q unchanged.
